// File: rtl/nibble_serial_add_ctrl_if.sv
//------------------------------------------------------------------------------
// nibble_serial_add_ctrl_if : requester handshake plus slice-adder bus
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
);
  // Requester side
  logic             start;
  logic             op_sub;
  logic             cin_in;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  // Slice adder side
  logic [SLICE-1:0] add_a;
  logic [SLICE-1:0] add_b;
  logic             add_cin;
  logic [SLICE-1:0] add_sum;
  logic             add_cout;

  modport master (
    output start, op_sub, cin_in, op_a, op_b,
    input  ready, busy, done, result, cout, ovf
  );

  modport slave (
    input  start, op_sub, cin_in, op_a, op_b, add_sum, add_cout,
    output ready, busy, done, result, cout, ovf, add_a, add_b, add_cin
  );

  modport adder (
    input  add_a, add_b, add_cin,
    output add_sum, add_cout
  );
endinterface

`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
//------------------------------------------------------------------------------
// nibble_serial_add_ctrl : WIDTH-bit add/sub sequenced over one shared SLICE adder
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  nibble_serial_add_ctrl_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.op_a;
      r_b     <= bus.op_sub ? ~bus.op_b : bus.op_b;
      r_carry <= bus.op_sub | bus.cin_in;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      for (int i = 0; i < NSLICE; i++) begin
        if (r_cnt == CW'(i)) begin
          r_result[i*SLICE +: SLICE] <= bus.add_sum;
        end
      end
      r_carry <= bus.add_cout;
      r_cnt   <= r_cnt + CW'(1);
      // Top slice sum is the result MSB, so flags settle in the same edge as the result
      if (w_last) begin
        r_cout <= bus.add_cout;
        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                  (bus.add_sum[SLICE-1] != r_a[WIDTH-1]);
      end
    end
  end

  always_comb begin
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_cin = 1'b0;
    if (r_state == S_RUN) begin
      bus.add_cin = r_carry;
      for (int i = 0; i < NSLICE; i++) begin
        if (r_cnt == CW'(i)) begin
          bus.add_a = r_a[i*SLICE +: SLICE];
          bus.add_b = r_b[i*SLICE +: SLICE];
        end
      end
    end
  end

  assign bus.ready  = (r_state == S_IDLE);
  assign bus.busy   = (r_state == S_RUN);
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.ovf    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
//------------------------------------------------------------------------------
// tb_nibble_serial_add_ctrl : directed checks of the slice-serial add/sub sequencer
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_nibble_serial_add_ctrl;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   n;
  int   idx;
  logic [SLICE-1:0] seq [NSLICE];

  nibble_serial_add_ctrl_if #(.WIDTH(WIDTH), .SLICE(SLICE)) bus ();

  nibble_serial_add_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural model of the external combinational slice adder
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{SLICE{1'b0}}, bus.add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, input logic cin);
    bus.op_a   = a;
    bus.op_b   = b;
    bus.op_sub = sub;
    bus.cin_in = cin;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
  endtask

  task automatic wait_done();
    n   = 0;
    idx = 0;
    while (bus.done !== 1'b1 && n < 12) begin
      if (bus.busy === 1'b1 && idx < NSLICE) begin
        seq[idx] = bus.add_a;
        idx++;
      end
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic sub, input logic cin, input logic [WIDTH-1:0] er,
                        input logic ec, input logic eo);
    start_op(a, b, sub, cin);
    wait_done();
    chk({tag, "_latency"}, n, NSLICE);
    chk({tag, "_result"}, bus.result, er);
    chk({tag, "_cout"}, bus.cout, ec);
    chk({tag, "_ovf"}, bus.ovf, eo);
    @(posedge clk);
    #1;
    chk({tag, "_idle_ready"}, bus.ready, 1'b1);
    chk({tag, "_held"}, bus.result, er);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.op_sub = 1'b0;
    bus.cin_in = 1'b0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_result", bus.result, 16'h0000);
    chk("rst_cout", bus.cout, 1'b0);
    chk("rst_addpins", {bus.add_a, bus.add_b, bus.add_cin}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add_ff_1", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    chk("adda_seq", {seq[0], seq[1], seq[2], seq[3]}, 16'hFF00);
    chk("adda_cnt", idx, NSLICE);

    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_cin", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // New request raised while busy and held through DONE must be ignored
    start_op(16'h0011, 16'h0022, 1'b0, 1'b0);
    bus.op_a   = 16'hAAAA;
    bus.op_b   = 16'h5555;
    bus.op_sub = 1'b1;
    bus.start  = 1'b1;
    chk("ign_ready_run", bus.ready, 1'b0);
    chk("ign_busy_run", bus.busy, 1'b1);
    wait_done();
    chk("ign_latency", n, NSLICE);
    chk("ign_result", bus.result, 16'h0033);
    chk("ign_cout", bus.cout, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("ign_back_idle", bus.ready, 1'b1);
    @(posedge clk);
    #1;
    chk("ign_no_accept", bus.ready, 1'b1);
    chk("ign_result_kept", bus.result, 16'h0033);
    run_op("after_ign", 16'h1000, 16'h2000, 1'b0, 1'b0, 16'h3000, 1'b0, 1'b0);

    // Reset in the second RUN cycle aborts without a done pulse
    start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("abort_busy_before", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", bus.ready, 1'b1);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_result", bus.result, 16'h0000);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_adda", bus.add_a, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < NSLICE + 2; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) n++;
    end
    chk("abort_no_done", n, 0);
    chk("abort_idle", bus.ready, 1'b1);
    @(negedge clk);
    run_op("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that performs WIDTH-bit add/subtract by driving one shared SLICE-bit ripple-carry adder, one slice per clock cycle, LSB slice first.
- Registers the inter-slice carry and assembles the full result.
- Sits between a requester (start/ready/done handshake) and an external combinational ripple_carry_adder instance. The adder's a/b/cin/sum/cout connect to the add_* ports.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of SLICE.
- SLICE, 4, adder slice width; matches the attached adder.
- NSLICE, WIDTH/SLICE, derived local parameter; number of slice cycles per operation.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when ready=1.
- op_sub  in  1  0 = A+B+cin_in, 1 = A-B (cin_in ignored); sampled with start.
- cin_in  in  1  carry-in for add; sampled with start.
- op_a  in  WIDTH  operand A; sampled with start.
- op_b  in  WIDTH  operand B; sampled with start.
- ready  out  1  high in IDLE only.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when result is valid.
- result  out  WIDTH  sum/difference; held until next accepted start.
- cout  out  1  final carry; for subtract, 1 = no borrow.
- ovf  out  1  signed overflow of the last operation.
- add_a  out  SLICE  slice of A to adder.
- add_b  out  SLICE  slice of effective B to adder.
- add_cin  out  1  carry to adder.
- add_sum  in  SLICE  adder sum; combinational, same cycle.
- add_cout  in  1  adder carry-out; combinational, same cycle.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, slice counter=0, carry reg=0, operand regs=0, result=0, cout=0, ovf=0, done=0, busy=0, ready=1, add_a/add_b/add_cin=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On start=1, latch a_reg=op_a and b_eff=(op_sub ? ~op_b : op_b).
  - Set carry reg = op_sub ? 1 : cin_in, and cnt=0.
  - Go to RUN.
  - start=0: stay.
- RUN: busy=1, ready=0.
  - Drive add_a=a_reg[cnt*SLICE +: SLICE], add_b=b_eff[cnt*SLICE +: SLICE], add_cin=carry reg.
  - At the clock edge: result[cnt slice]<=add_sum, carry<=add_cout, cnt<=cnt+1.
  - When cnt==NSLICE-1, go to DONE instead.
  - Exactly NSLICE RUN cycles per operation.
- DONE:
  - done=1 for exactly this one cycle; cout=carry reg.
  - ovf=(a_reg[MSB]==b_eff[MSB]) && (result[MSB]!=a_reg[MSB]).
  - Next cycle go to IDLE unconditionally.
- Outside RUN: add_a, add_b, add_cin are driven 0.
- Latency: start accepted at edge k; done high in the cycle following edge k+NSLICE. Throughput is one operation per NSLICE+2 cycles.
- start while busy or in DONE is ignored: no latching, no queuing. The requester must hold start until it sees ready.
- result, cout and ovf keep the last values from DONE until the next accepted start. Partial slices may overwrite result during RUN; result is only valid when done=1 and until the next start.
- Operand changes on op_a/op_b/op_sub/cin_in after acceptance have no effect on the running operation.
- Reset asserted mid-RUN aborts immediately to the reset values. No done pulse is produced for the aborted operation.
- Arithmetic is modulo 2^WIDTH; cout carries the bit WIDTH of the true sum.

Test Plan:
- WIDTH=16, add 0x00FF + 0x0001, cin_in=0 -> done after 5 cycles; result=0x0100, cout=0, ovf=0. Check add_a sequence 0xF,0xF,0x0,0x0 on cycles 1-4.
- Add 0xFFFF + 0x0001, cin_in=0 -> result=0x0000, cout=1, ovf=0. Also add 0xFFFF + 0xFFFF, cin_in=1 -> result=0xFFFF, cout=1.
- Subtract 0x0005 - 0x0007 -> result=0xFFFE, cout=0 (borrow), ovf=0. Also subtract 0x0007 - 0x0005 -> result=0x0002, cout=1.
- Add 0x7FFF + 0x0001 -> result=0x8000, ovf=1. Subtract 0x8000 - 0x0001 -> result=0x7FFF, ovf=1.
- Pulse start with new operands during RUN and during DONE -> ignored. First result unchanged, ready stays 0 in RUN. A second start in IDLE is accepted normally.
- Drop rst_n during the 2nd RUN cycle -> immediately ready=1, busy=0, result=0, no done. A fresh 0x1234 + 0x1111 afterwards gives result=0x2345.
